// File: rtl/paddle_input_ctrl.sv
// Paddle input conditioner: sync + debounce two buttons, resolve presses, ramp speed while held.
// Latency: up/down follow a raw button change by DEBOUNCE_CYCLES+3 rising edges.
// Backpressure: none; outputs are level signals sampled by the Paddle every cycle.

// Two-flop synchronizer followed by a stable-for-N-cycles debouncer for one button.
module paddle_btn_debounce #(
  parameter int CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic deb_o
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  logic             s1_q, s2_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Two-stage synchronizer; the raw button is asynchronous to clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
    end
  end

  // Count consecutive cycles the synchronized level disagrees with the debounced one;
  // flip the debounced value once the disagreement has lasted CYCLES cycles.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (s2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

module paddle_input_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 50000,
  parameter int ACCEL_HOLD_CYCLES = 2500000,
  parameter int TICKS_SLOW        = 50,
  parameter int TICKS_FAST        = 10,
  parameter int ACCEL_STEP        = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_up_raw,
  input  logic               btn_down_raw,
  input  logic               game_on,
  output logic               up,
  output logic               down,
  output logic signed [31:0] ticks_per_px
);

  localparam int HOLD_W = (ACCEL_HOLD_CYCLES > 1) ? $clog2(ACCEL_HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ACCEL_HOLD_CYCLES - 1);

  localparam logic signed [31:0] SLOW_S = 32'(TICKS_SLOW);
  localparam logic signed [31:0] FAST_S = 32'(TICKS_FAST);
  localparam logic signed [31:0] STEP_S = 32'(ACCEL_STEP);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    BOTH      = 2'd3
  } state_e;

  logic du, dd;

  state_e              state_q, state_d;
  logic                up_q, up_d;
  logic                down_q, down_d;
  logic signed [31:0]  ticks_q, ticks_d;
  logic signed [31:0]  ticks_dec;
  logic [HOLD_W-1:0]   hold_q, hold_d;

  paddle_btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .clk   (clk),
    .reset (reset),
    .raw_i (btn_up_raw),
    .deb_o (du)
  );

  paddle_btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
    .clk   (clk),
    .reset (reset),
    .raw_i (btn_down_raw),
    .deb_o (dd)
  );

  // State and registered outputs; reset forces the paddle to stop immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      ticks_q <= SLOW_S;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      up_q    <= up_d;
      down_q  <= down_d;
      ticks_q <= ticks_d;
      hold_q  <= hold_d;
    end
  end

  // Next state depends only on the debounced buttons and game_on; prior state does not matter.
  always_comb begin
    state_d = IDLE;
    if (game_on) begin
      unique case ({du, dd})
        2'b11:   state_d = BOTH;
        2'b10:   state_d = MOVE_UP;
        2'b01:   state_d = MOVE_DOWN;
        default: state_d = IDLE;
      endcase
    end
  end

  // One speed step, clamped to the fast floor; ticks_q never drops below TICKS_FAST.
  assign ticks_dec = ticks_q - STEP_S;

  // Outputs and acceleration ramp are derived from the next state so they register with it.
  always_comb begin
    up_d    = (state_d == MOVE_UP);
    down_d  = (state_d == MOVE_DOWN);
    ticks_d = SLOW_S;
    hold_d  = '0;
    // Only a continued hold in the same direction keeps ramping; any entry restarts slow.
    if ((up_d || down_d) && (state_d == state_q)) begin
      if (hold_q == HOLD_LAST) begin
        hold_d  = '0;
        ticks_d = (ticks_dec < FAST_S) ? FAST_S : ticks_dec;
      end else begin
        hold_d  = hold_q + 1'b1;
        ticks_d = ticks_q;
      end
    end
  end

  assign up           = up_q;
  assign down         = down_q;
  assign ticks_per_px = ticks_q;

endmodule

// File: tb/tb_paddle_input_ctrl.sv
module tb_paddle_input_ctrl;

  logic               clk = 1'b0;
  logic               reset;
  logic               btn_up_raw;
  logic               btn_down_raw;
  logic               game_on;
  logic               up;
  logic               down;
  logic signed [31:0] ticks_per_px;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    int    cyc;
    logic  up;
    logic  down;
    int    ticks;
    string name;
  } exp_t;

  exp_t exp_q[$];

  paddle_input_ctrl #(
    .DEBOUNCE_CYCLES   (4),
    .ACCEL_HOLD_CYCLES (8),
    .TICKS_SLOW        (50),
    .TICKS_FAST        (10),
    .ACCEL_STEP        (15)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_up_raw   (btn_up_raw),
    .btn_down_raw (btn_down_raw),
    .game_on      (game_on),
    .up           (up),
    .down         (down),
    .ticks_per_px (ticks_per_px)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Queue an expected output value for a given cycle, kept sorted by cycle.
  task automatic expect_at(input int c, input logic u, input logic d, input int t, input string nm);
    exp_t e;
    int   i;
    e.cyc = c; e.up = u; e.down = d; e.ticks = t; e.name = nm;
    i = 0;
    while (i < exp_q.size() && exp_q[i].cyc <= c) i++;
    exp_q.insert(i, e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: samples on the falling edge and retires every expectation due this cycle.
  always @(negedge clk) begin
    n_checks++;
    if (up && down) $display("FAIL exclusive cyc=%0d got up=%0b down=%0b want not both", cyc, up, down);
    else n_pass++;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (e.cyc < cyc)
        $display("FAIL %s missed cyc=%0d (now %0d)", e.name, e.cyc, cyc);
      else if (up !== e.up || down !== e.down || ticks_per_px !== e.ticks)
        $display("FAIL %s cyc=%0d got up=%0b down=%0b ticks=%0d want up=%0b down=%0b ticks=%0d",
                 e.name, cyc, up, down, ticks_per_px, e.up, e.down, e.ticks);
      else
        n_pass++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset = 1'b0; btn_up_raw = 1'b0; btn_down_raw = 1'b0; game_on = 1'b1;

    // Reset held for two cycles, then released with buttons low.
    step(2);
    expect_at(cyc, 0, 0, 50, "reset_state");
    reset = 1'b1;
    expect_at(cyc + 3, 0, 0, 50, "idle_after_reset");
    step(6);

    // 3-cycle glitch on up is rejected.
    c = cyc;
    btn_up_raw = 1'b1;
    expect_at(c + 7,  0, 0, 50, "glitch_c7");
    expect_at(c + 8,  0, 0, 50, "glitch_c8");
    expect_at(c + 12, 0, 0, 50, "glitch_c12");
    step(3);
    btn_up_raw = 1'b0;
    step(12);

    // Hold up: exact latency, then ramp 50 -> 35 -> 20 -> 10 and saturate.
    c = cyc;
    btn_up_raw = 1'b1;
    expect_at(c + 6,  0, 0, 50, "up_latency_c6");
    expect_at(c + 7,  1, 0, 50, "up_latency_c7");
    expect_at(c + 14, 1, 0, 50, "up_hold_c14");
    expect_at(c + 15, 1, 0, 35, "up_step1");
    expect_at(c + 22, 1, 0, 35, "up_hold_c22");
    expect_at(c + 23, 1, 0, 20, "up_step2");
    expect_at(c + 31, 1, 0, 10, "up_step3_sat");
    expect_at(c + 39, 1, 0, 10, "up_sat_hold1");
    expect_at(c + 47, 1, 0, 10, "up_sat_hold2");
    step(48);

    // Press down while holding up -> BOTH; release up -> MOVE_DOWN with fresh ramp.
    c = cyc;
    btn_down_raw = 1'b1;
    expect_at(c + 6, 1, 0, 10, "both_c6");
    expect_at(c + 7, 0, 0, 50, "both_c7");
    step(10);
    c = cyc;
    btn_up_raw = 1'b0;
    expect_at(c + 6, 0, 0, 50, "both_to_down_c6");
    expect_at(c + 7, 0, 1, 50, "both_to_down_c7");
    expect_at(c + 15, 0, 1, 35, "down_step1");
    step(16);

    // Drop game_on while moving down at 35, then restore it.
    c = cyc;
    game_on = 1'b0;
    expect_at(c,     0, 1, 35, "gameoff_before");
    expect_at(c + 1, 0, 0, 50, "gameoff_after");
    step(3);
    c = cyc;
    game_on = 1'b1;
    expect_at(c,     0, 0, 50, "gameon_before");
    expect_at(c + 1, 0, 1, 50, "gameon_after");
    expect_at(c + 9, 0, 1, 35, "gameon_ramp");
    step(10);
    c = cyc;
    btn_down_raw = 1'b0;
    expect_at(c + 7, 0, 0, 50, "down_release");
    step(10);

    // Reach 20 on up, then assert reset between edges.
    c = cyc;
    btn_up_raw = 1'b1;
    expect_at(c + 7,  1, 0, 50, "up2_start");
    expect_at(c + 23, 1, 0, 20, "up2_at20");
    step(24);
    #1;
    reset = 1'b0;
    expect_at(cyc, 0, 0, 50, "async_reset");
    step(2);
    c = cyc;
    reset = 1'b1;
    expect_at(c + 6, 0, 0, 50, "post_reset_c6");
    expect_at(c + 7, 1, 0, 50, "post_reset_c7");
    step(10);

    step(2);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      $display("FAIL %s never checked (cyc=%0d)", e.name, e.cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
